// File: rtl/div_pkg.sv
// Shared constants and state encoding for the divider sweep checker.
package div_pkg;

  // Default operand / result widths of the divider under test.
  localparam int XW_DEF = 4;
  localparam int YW_DEF = 2;
  localparam int QW_DEF = 3;
  localparam int RW_DEF = 3;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FIN    = 2'd3
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // 8-bit counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/div_expect.sv
// Reference quotient/remainder for one operand pair, plus the decision
// whether the true quotient fits in the array's QW-bit result.
module div_expect
  import div_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF,
  parameter int QW = QW_DEF
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] e_q,
  output logic [YW-1:0] e_r,
  output logic          ovf
);

  // Common width so divisor wider than dividend is still exact.
  localparam int DW = max2(XW, YW);
  // One spare bit so QMAX never truncates even when QW >= XW.
  localparam int OW = max2(XW, QW) + 1;
  localparam logic [OW-1:0] QMAX = OW'((64'd1 << QW) - 64'd1);

  logic [DW-1:0] xe, ye;

  assign xe = DW'(x);
  assign ye = DW'(y);

  // Full-width divide; a zero divisor is never swept but is guarded anyway.
  always_comb begin
    e_q = '0;
    e_r = '0;
    if (ye != '0) begin
      e_q = XW'(xe / ye);
      e_r = YW'(xe % ye);
    end
    ovf = (OW'(e_q) > QMAX);
  end

endmodule

// File: rtl/div_sweep_checker.sv
// Exhaustive sweep of every (x, y!=0) pair into an external divider array,
// comparing its quotient/remainder against div_expect and keeping error,
// overflow and first-mismatch records.
module div_sweep_checker
  import div_pkg::*;
#(
  parameter int XW         = XW_DEF,
  parameter int YW         = YW_DEF,
  parameter int QW         = QW_DEF,
  parameter int RW         = RW_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  input  logic [QW-1:0] q_in,
  input  logic [RW-1:0] r_in,
  output logic          busy,
  output logic          done,
  output logic [7:0]    err_cnt,
  output logic [7:0]    ovf_cnt,
  output logic          mismatch,
  output logic          mis_valid,
  output logic [XW-1:0] mis_x,
  output logic [YW-1:0] mis_y
);

  localparam int SCW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SCW-1:0] LAST_CNT = SCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  // With no settle time each vector is a single CHECK cycle.
  localparam state_t VEC_ST = (SETTLE_CYC == 0) ? CHECK : SETTLE;
  localparam int CW = max2(max2(XW, QW), max2(YW, RW));

  state_t         state;
  logic [SCW-1:0] settle_cnt;

  logic [XW-1:0]  e_q;
  logic [YW-1:0]  e_r;
  logic           ovf;
  logic           diff;
  logic           last_vec;

  div_expect #(.XW(XW), .YW(YW), .QW(QW)) u_expect (
    .x   (x_out),
    .y   (y_out),
    .e_q (e_q),
    .e_r (e_r),
    .ovf (ovf)
  );

  // Compare in a common width so any QW/RW vs XW/YW mix is exact.
  assign diff     = (CW'(q_in) != CW'(e_q)) || (CW'(r_in) != CW'(e_r));
  assign last_vec = (x_out == '1) && (y_out == '1);

  // Pulse is combinational so it lines up with the CHECK cycle that
  // observed the bad result; the state register keeps it low elsewhere.
  assign mismatch = (state == CHECK) && !ovf && diff;

  // Sweep sequencer: operand generation, settle timing, scoring.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      x_out      <= '0;
      y_out      <= YW'(1);
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      ovf_cnt    <= '0;
      mis_valid  <= 1'b0;
      mis_x      <= '0;
      mis_y      <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state      <= VEC_ST;
            settle_cnt <= '0;
            x_out      <= '0;
            y_out      <= YW'(1);
            busy       <= 1'b1;
            done       <= 1'b0;
            err_cnt    <= '0;
            ovf_cnt    <= '0;
            mis_valid  <= 1'b0;
            mis_x      <= '0;
            mis_y      <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == LAST_CNT) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + SCW'(1);
          end
        end
        CHECK: begin
          // Overflowing quotients cannot be represented, so they are
          // tallied separately and never judged.
          if (ovf) begin
            ovf_cnt <= sat_inc8(ovf_cnt);
          end else if (diff) begin
            err_cnt <= sat_inc8(err_cnt);
            if (!mis_valid) begin
              mis_valid <= 1'b1;
              mis_x     <= x_out;
              mis_y     <= y_out;
            end
          end
          if (last_vec) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= VEC_ST;
            // y runs 1..max then wraps to 1 and carries into x.
            if (y_out == '1) begin
              y_out <= YW'(1);
              x_out <= x_out + XW'(1);
            end else begin
              y_out <= y_out + YW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
